ring_step_ctrl: RTL
===================

// Module: ring_step_ctrl
// PURPOSE
//  Upstream driver and downstream judge for the 15-lamp one-hot ring counter.
//  - Debounces the player button.
//  - Generates the single-cycle step enable that feeds the ring counter's Start input.
//  - Freezes the ring when the button is pressed, then samples the one-hot position.
//  - Scores a hit when the frozen lamp equals TARGET.
// PARAMETERS
//  N        15         ring width; pos is N bits, IW = $clog2(N)
//  DIV      1_000_000  clk cycles per ring step
//  DEB_CYC  20_000     consecutive stable cycles required to accept a button level
//  TARGET   7          index of the winning lamp, 0..N-1
//  SCORE_W  4          score counter width
//  DIV_MIN  250_000    minimum step period; used only with RING_SPEEDUP_EN
// PORTS
//  clk      in   1        system clock
//  rst_n    in   1        asynchronous, active-low reset
//  btn      in   1        raw asynchronous push button, active high
//  pos      in   N        one-hot ring position, fed back from the ring counter
//  step     out  1        one-cycle step enable to the ring counter's Start input
//  running  out  1        high while in RUN
//  hit      out  1        last judgement matched TARGET; held until the next RUN
//  miss     out  1        last judgement did not match TARGET; held until the next RUN
//  pos_idx  out  IW       binary index of the frozen lamp
//  score    out  SCORE_W  hit count; saturating; cleared only by rst_n
// BEHAVIOUR
//  Reset
//  - rst_n low clears immediately (asynchronous): all outputs 0, state IDLE,
//    prescaler 0, debounced level 0, synchronizer flops 0.
//  - Asserting rst_n mid-operation behaves the same way. The ring counter shares
//    rst_n, so it returns to bit 14.
//  Input
//  - btn passes through a 2-FF synchronizer.
//  - Debounced level toggles after DEB_CYC consecutive cycles in which the
//    synchronized level differs from it. Any bounce restarts the count.
//  - press is a 1-cycle pulse in the cycle after the debounced level rises.
//    Release produces no pulse.
//  FSM: IDLE -> RUN -> JUDGE -> SHOW -> RUN ...
//  - IDLE: step=0. press -> RUN; hit/miss cleared; prescaler cleared.
//  - RUN: running=1. Prescaler counts 0..per-1 and wraps to 0.
//      - step=1 for exactly the cycle in which prescaler==per-1.
//      - press -> JUDGE. press wins over a coincident terminal count: no step
//        that cycle, and the prescaler is held.
//  - JUDGE (1 cycle): step=0, so pos is stable; pos is sampled here.
//      - pos_idx = index of the set bit.
//      - hit if pos == (1<<TARGET); miss otherwise.
//      - Non-one-hot pos (zero or multiple bits): miss=1, pos_idx=0.
//      - On hit, score increments, saturating at 2^SCORE_W-1.
//      - -> SHOW.
//  - SHOW: step=0; hit/miss/pos_idx held. press -> RUN; hit/miss cleared;
//    prescaler restarts from 0.
//  Timing
//  - All outputs are registered. running rises the cycle after the accepting press.
//  - hit/miss/pos_idx/score update on the clock edge ending JUDGE.
//  - step never asserts outside RUN. Two step pulses are never closer than
//    per cycles.
//  Arithmetic
//  - per is a register of width $clog2(DIV+1), reset to DIV.
//  - score adds 1 only on hit and below maximum.
// CONFIGURATION
//  RING_SPEEDUP_EN defined:
//  - On each hit, in the JUDGE edge: per <= max(per - (per>>2), DIV_MIN).
//  - per is restored to DIV only by rst_n.
//  RING_SPEEDUP_EN undefined:
//  - per is the constant DIV; DIV_MIN is unused; no extra logic.
// STRUCTURE
//  - Package ring_pkg holds:
//      - the state enum typedef (IDLE, RUN, JUDGE, SHOW), 2 bits;
//      - default constants RING_N=15 and RING_TARGET=7;
//      - function onehot2idx(pos) returning the index, or 0 when not one-hot.
//  - One sub-module: btn_debounce (synchronizer + stability counter + rise
//    pulse), with parameter DEB_CYC and ports clk, rst_n, btn, level, press.
//  - The FSM, prescaler and judge stay in ring_step_ctrl.
// TESTING (bench overrides DIV=4, DEB_CYC=2, DIV_MIN=2; ring counter in loop)
//  1. Reset, btn=0 for 100 cycles -> step never 1; pos stays 15'h4000; all outputs 0.
//  2. btn held high -> running=1 at a fixed latency; step pulses 1 cycle wide,
//     exactly every 4 cycles. A 1-cycle btn glitch is ignored.
//  3. Press while pos=15'h0080 -> hit=1, miss=0, pos_idx=7, score=1; no further
//     step; pos frozen until the next press.
//  4. Press while pos=15'h0008 -> miss=1, pos_idx=3, score unchanged. Next press
//     clears miss and resumes stepping from 15'h0010.
//  5. 17 hits -> score reaches 15 and stays 15. With RING_SPEEDUP_EN the step
//     interval goes 4 -> 3 -> 3 -> ... and never falls below 2.
//  6. Drop rst_n mid-RUN between clock edges -> outputs 0 immediately;
//     pos=15'h4000; after release the FSM stays IDLE until a new press.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the lamp-ring step controller.
// Holds the controller state encoding, the default ring geometry and the
// one-hot to index decoder used when the ring is frozen.
package ring_pkg;

    localparam int RING_N      = 15;
    localparam int RING_TARGET = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        JUDGE = 2'd2,
        SHOW  = 2'd3
    } ring_state_e;

    // Index of the single set bit; 0 when the vector is zero or has several bits set.
    function automatic logic [4:0] onehot2idx(input logic [31:0] vec);
        logic [4:0] idx;
        logic [5:0] cnt;
        idx = 5'd0;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            idx = vec[i] ? 5'(i) : idx;
            cnt = cnt + {5'd0, vec[i]};
        end
        return (cnt == 6'd1) ? idx : 5'd0;
    endfunction

endpackage

// File: rtl/ring_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter that accepts
// a new level only after DEB_CYC consecutive differing cycles, and a
// one-cycle pulse in the cycle after the accepted level rises.
module btn_debounce #(
    parameter int DEB_CYC = 20_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Synchronize the raw button, filter bounces and detect the rising level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= {CW{1'b0}};
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEB_CYC - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= {CW{1'b0}};
                end else begin
                    r_cnt   <= r_cnt + CW'(1);
                end
            end else begin
                // Any return to the accepted level restarts the stability count.
                r_cnt <= {CW{1'b0}};
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/ring_step_ctrl.sv
// Step driver and judge for the one-hot lamp ring.
// Produces the ring's step enable from a prescaler, freezes the ring on a
// player press, decodes the frozen lamp and keeps a saturating hit score.
// Optional feature macro: RING_SPEEDUP_EN -- each hit shortens the step
// period by a quarter, never below DIV_MIN; only rst_n restores DIV.
module ring_step_ctrl
    import ring_pkg::*;
#(
    parameter  int N       = RING_N,
    parameter  int DIV     = 1_000_000,
    parameter  int DEB_CYC = 20_000,
    parameter  int TARGET  = RING_TARGET,
    parameter  int SCORE_W = 4,
    parameter  int DIV_MIN = 250_000,
    localparam int IW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn,
    input  logic [N-1:0]       pos,
    output logic               step,
    output logic               running,
    output logic               hit,
    output logic               miss,
    output logic [IW-1:0]      pos_idx,
    output logic [SCORE_W-1:0] score
);

    // Period register must hold both the start period and the floor.
    localparam int PER_MAX = (DIV > DIV_MIN) ? DIV : DIV_MIN;
    localparam int PW      = $clog2(PER_MAX + 1);
    localparam logic [N-1:0] TGT_VEC = N'(1) << TARGET;

    ring_state_e        r_state;
    logic [PW-1:0]      r_presc;
    logic               r_step;
    logic               r_running;
    logic               r_hit;
    logic               r_miss;
    logic [IW-1:0]      r_pos_idx;
    logic [SCORE_W-1:0] r_score;

    logic               w_level;
    logic               w_press_raw;
    logic               w_press;
    logic [PW-1:0]      w_per;
    logic               w_last;
    logic               w_judge_hit;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .level (w_level),
        .press (w_press_raw)
    );

    // A press is honoured only while the accepted level is still high.
    assign w_press     = w_press_raw & w_level;
    assign w_last      = (r_presc == (w_per - PW'(1)));
    assign w_judge_hit = (pos == TGT_VEC);

`ifdef RING_SPEEDUP_EN
    logic [PW-1:0] r_per;
    logic [PW-1:0] w_per_dec;
    logic [PW-1:0] w_per_next;

    // Next period after a hit: three quarters of the current one, floored.
    always_comb begin
        w_per_dec = r_per - (r_per >> 2);
        if (w_per_dec < PW'(DIV_MIN)) begin
            w_per_next = PW'(DIV_MIN);
        end else begin
            w_per_next = w_per_dec;
        end
    end

    // Shorten the step period on every hit, at the edge ending JUDGE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per <= PW'(DIV);
        end else if ((r_state == JUDGE) && w_judge_hit) begin
            r_per <= w_per_next;
        end else begin
            r_per <= r_per;
        end
    end

    assign w_per = r_per;
`else
    assign w_per = PW'(DIV);
`endif

    // Controller FSM with prescaler, registered step enable and judgement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_presc   <= {PW{1'b0}};
            r_step    <= 1'b0;
            r_running <= 1'b0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_pos_idx <= {IW{1'b0}};
            r_score   <= {SCORE_W{1'b0}};
        end else begin
            case (r_state)
                IDLE, SHOW: begin
                    r_step <= 1'b0;
                    if (w_press) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_hit     <= 1'b0;
                        r_miss    <= 1'b0;
                        r_presc   <= {PW{1'b0}};
                    end else begin
                        r_running <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_press) begin
                        // Press beats a coincident terminal count; prescaler holds.
                        r_state   <= JUDGE;
                        r_running <= 1'b0;
                        r_step    <= 1'b0;
                    end else if (w_last) begin
                        r_presc   <= {PW{1'b0}};
                        r_step    <= 1'b1;
                        r_running <= 1'b1;
                    end else begin
                        r_presc   <= r_presc + PW'(1);
                        r_step    <= 1'b0;
                        r_running <= 1'b1;
                    end
                end
                JUDGE: begin
                    // Ring is stable here because no step was issued this cycle.
                    r_state   <= SHOW;
                    r_step    <= 1'b0;
                    r_running <= 1'b0;
                    r_hit     <= w_judge_hit;
                    r_miss    <= ~w_judge_hit;
                    r_pos_idx <= IW'(onehot2idx(32'(pos)));
                    if (w_judge_hit && (r_score != {SCORE_W{1'b1}})) begin
                        r_score <= r_score + SCORE_W'(1);
                    end else begin
                        r_score <= r_score;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_step    <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign step    = r_step;
    assign running = r_running;
    assign hit     = r_hit;
    assign miss    = r_miss;
    assign pos_idx = r_pos_idx;
    assign score   = r_score;

endmodule
